// File: rtl/instr_sequencer_if.sv
// Instruction-sequencer bus: ROM/handshake inputs and program-flow outputs.
// master = sequencer side, slave = core/ROM/environment side.
interface instr_sequencer_if #(
    parameter int unsigned INSTR_WIDTH      = 12,
    parameter int unsigned INSTR_ADDR_WIDTH = 4,
    parameter int unsigned STACK_DEPTH      = 4
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic [INSTR_WIDTH-1:0]      instr;
    logic                        ready_in;
    logic                        halt_req;
    logic [INSTR_ADDR_WIDTH-1:0] pc;
    logic                        issue;
    logic [1:0]                  state;
    logic [SP_W-1:0]             sp;
    logic                        stack_err;
    logic                        wait_timeout;

    modport master (
        input  instr, ready_in, halt_req,
        output pc, issue, state, sp, stack_err, wait_timeout
    );

    modport slave (
        output instr, ready_in, halt_req,
        input  pc, issue, state, sp, stack_err, wait_timeout
    );
endinterface

// File: rtl/instr_sequencer.sv
// Program-flow controller: PC, WAIT on ready_in (level/edge), JMP/CALL/RET with return stack, halt.
// Optional WAIT_TIMEOUT_EN macro adds a WAIT cycle limit that forces the PC past a stuck WAIT.
`ifndef WAIT
`define WAIT 3'b001
`endif
`ifndef JMP
`define JMP 3'b010
`endif
`ifndef CALL
`define CALL 3'b011
`endif
`ifndef RET
`define RET 3'b100
`endif

module instr_sequencer #(
    parameter int unsigned INSTR_WIDTH      = 12,
    parameter int unsigned INSTR_ADDR_WIDTH = 4,
    parameter int unsigned STACK_DEPTH      = 4,
    parameter int unsigned WAIT_TIMEOUT     = 255
) (
    input logic               clk,
    input logic               n_reset,
    instr_sequencer_if.master sq
);
    localparam int unsigned AW    = INSTR_ADDR_WIDTH;
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_pc, w_pc_nxt, w_pc_inc, w_target, w_pop_pc;
    logic [SP_W-1:0] r_sp, w_sp_nxt;
    logic [AW-1:0]   r_stack [STACK_DEPTH];
    logic            r_stack_err, r_wait_to, r_rdy_q;
    logic            w_issue, w_push, w_err_set, w_to_set, w_to_hit;
    logic [2:0]      w_opcode;
    logic            w_edge, w_cond, w_met;
    logic            w_unused_instr;

    assign w_opcode       = sq.instr[INSTR_WIDTH-1 -: 3];
    assign w_edge         = sq.ready_in & ~r_rdy_q;
    assign w_cond         = sq.instr[3] ? w_edge : sq.ready_in;
    assign w_met          = (w_cond == sq.instr[0]);
    assign w_pc_inc       = r_pc + AW'(1);
    assign w_target       = sq.instr[AW-1:0];
    assign w_pop_pc       = r_stack[IDX_W'(r_sp - SP_W'(1))];
    assign w_unused_instr = ^sq.instr;

    // Next-state / issue decode, priority: halt, WAIT, JMP, CALL, RET, sequential
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sp_nxt    = r_sp;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_err_set   = 1'b0;
        w_to_set    = 1'b0;
        case (r_state)
            ST_FAULT: ;
            ST_HALT: begin
                if (!sq.halt_req) w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
                if (sq.halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (w_opcode == `WAIT) begin
                    if (w_met) begin
                        w_issue  = 1'b1;
                        w_pc_nxt = w_pc_inc;
                    end else if (w_to_hit) begin
                        w_pc_nxt = w_pc_inc;
                        w_to_set = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else if (w_opcode == `JMP) begin
                    w_issue  = 1'b1;
                    w_pc_nxt = w_target;
                end else if (w_opcode == `CALL) begin
                    if (r_sp < SP_W'(STACK_DEPTH)) begin
                        w_issue  = 1'b1;
                        w_push   = 1'b1;
                        w_sp_nxt = r_sp + SP_W'(1);
                        w_pc_nxt = w_target;
                    end else begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end
                end else if (w_opcode == `RET) begin
                    if (r_sp != '0) begin
                        w_issue  = 1'b1;
                        w_sp_nxt = r_sp - SP_W'(1);
                        w_pc_nxt = w_pop_pc;
                    end else begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end
                end else begin
                    w_issue  = 1'b1;
                    w_pc_nxt = w_pc_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= ST_RUN;
            r_pc        <= '0;
            r_sp        <= '0;
            r_stack_err <= 1'b0;
            r_wait_to   <= 1'b0;
            r_rdy_q     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_sp    <= w_sp_nxt;
            r_rdy_q <= sq.ready_in;
            if (w_err_set) r_stack_err <= 1'b1;
            if (w_to_set)  r_wait_to   <= 1'b1;
        end
    end

    // Return-stack storage is deliberately left unreset; only sp qualifies it
    always_ff @(posedge clk) begin
        if (w_push) r_stack[IDX_W'(r_sp)] <= w_pc_inc;
    end

`ifdef WAIT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);
    logic [CNT_W-1:0] r_wcnt;

    // Counts consecutive unmet-WAIT cycles; any other outcome (incl. HALT) clears it
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)                    r_wcnt <= '0;
        else if (w_state_nxt == ST_WAIT) r_wcnt <= r_wcnt + CNT_W'(1);
        else                             r_wcnt <= '0;
    end
    assign w_to_hit = (r_wcnt == CNT_W'(WAIT_TIMEOUT));
`else
    localparam int unsigned UNUSED_WAIT_TIMEOUT = WAIT_TIMEOUT;
    assign w_to_hit = 1'b0;
`endif

    assign sq.pc           = r_pc;
    assign sq.issue        = w_issue & n_reset;
    assign sq.state        = 2'(r_state);
    assign sq.sp           = r_sp;
    assign sq.stack_err    = r_stack_err;
    assign sq.wait_timeout = r_wait_to;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized programs
// compared against a queue-based program-flow model.
`ifndef WAIT
`define WAIT 3'b001
`endif
`ifndef JMP
`define JMP 3'b010
`endif
`ifndef CALL
`define CALL 3'b011
`endif
`ifndef RET
`define RET 3'b100
`endif

module tb_instr_sequencer;
    localparam int unsigned IW  = 12;
    localparam int unsigned AW  = 4;
    localparam int unsigned SD  = 4;
    localparam int unsigned WT  = 8;
    localparam int unsigned PS  = 16;
    localparam int unsigned SPW = $clog2(SD + 1);
    localparam int unsigned VW  = AW + 2 + SPW + 3;
`ifdef WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    instr_sequencer_if #(.INSTR_WIDTH(IW), .INSTR_ADDR_WIDTH(AW), .STACK_DEPTH(SD)) bus ();

    instr_sequencer #(
        .INSTR_WIDTH(IW), .INSTR_ADDR_WIDTH(AW), .STACK_DEPTH(SD), .WAIT_TIMEOUT(WT)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .sq(bus)
    );

    logic [IW-1:0] rom [PS];
    assign bus.instr = rom[bus.pc];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state only
    int m_pc, m_state, m_wcnt;
    int m_stack[$];
    bit m_err, m_to, m_rdyq;
    int n_pc, n_state, n_wcnt;
    int n_stack[$];
    bit n_err, n_to, cur_rdy, exp_issue;
    logic [VW-1:0] exp_vec;

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input int unsigned low);
        return {op, 9'(low)};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {bus.pc, bus.state, bus.sp, bus.issue, bus.stack_err, bus.wait_timeout};
    endfunction

    function automatic string fmt(input logic [VW-1:0] v);
        return $sformatf("pc=%0d st=%0d sp=%0d issue=%0d err=%0d to=%0d",
                         v[11:8], v[7:6], v[5:3], v[2], v[1], v[0]);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < PS; i++) rom[i] = '0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_state = 0; m_wcnt = 0;
        m_stack.delete();
        m_err = 0; m_to = 0; m_rdyq = 0;
    endtask

    task automatic model_eval(input bit rdy, input bit halt);
        logic [IW-1:0] ins;
        logic [2:0] op;
        bit e, cond, met;
        ins = rom[m_pc];
        op  = ins[11:9];
        e    = rdy && !m_rdyq;
        cond = ins[3] ? e : rdy;
        met  = (cond == ins[0]);
        n_pc = m_pc; n_state = m_state; n_wcnt = m_wcnt; n_stack = m_stack;
        n_err = m_err; n_to = m_to; exp_issue = 0; cur_rdy = rdy;
        if (m_state == 3) begin
        end else if (m_state == 2) begin
            if (!halt) n_state = 0;
        end else begin
            n_state = 0; n_wcnt = 0;
            if (halt) n_state = 2;
            else if (op == `WAIT) begin
                if (met) begin exp_issue = 1; n_pc = (m_pc + 1) % PS; end
                else if (TO_EN && m_wcnt == WT) begin n_pc = (m_pc + 1) % PS; n_to = 1; end
                else begin n_state = 1; n_wcnt = m_wcnt + 1; end
            end else if (op == `JMP) begin
                exp_issue = 1; n_pc = int'(ins) % PS;
            end else if (op == `CALL) begin
                if (m_stack.size() < SD) begin
                    exp_issue = 1; n_stack.push_back((m_pc + 1) % PS); n_pc = int'(ins) % PS;
                end else begin n_err = 1; n_state = 3; end
            end else if (op == `RET) begin
                if (m_stack.size() > 0) begin exp_issue = 1; n_pc = n_stack.pop_back(); end
                else begin n_err = 1; n_state = 3; end
            end else begin
                exp_issue = 1; n_pc = (m_pc + 1) % PS;
            end
        end
        exp_vec = {AW'(m_pc), 2'(m_state), SPW'(m_stack.size()), exp_issue, m_err, m_to};
    endtask

    // Called at a falling edge: drive inputs and compute expectations for this cycle
    task automatic begin_cycle(input bit rdy, input bit halt);
        bus.ready_in = rdy;
        bus.halt_req = halt;
        #1;
        model_eval(rdy, halt);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        m_pc = n_pc; m_state = n_state; m_wcnt = n_wcnt; m_stack = n_stack;
        m_err = n_err; m_to = n_to; m_rdyq = cur_rdy;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        n_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = mk(`CALL, 4);
        rom[4] = mk(`CALL, 5);
        bus.ready_in = 1'b0; bus.halt_req = 1'b0;
        n_reset = 1'b1;
        #1 n_reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== VW'(0)) begin
            n_fail++; $display("FAIL reset_initial: got %s exp all zero", fmt(obs()));
        end
        @(negedge clk); @(negedge clk);
        model_reset();
        n_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            begin_cycle(1'b0, 1'b0);
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL reset_prog: got %s exp %s", fmt(obs()), fmt(exp_vec));
            end
            end_cycle();
        end
        n_checks++;
        if (bus.pc !== 4'd5 || bus.sp !== 3'd2) begin
            n_fail++; $display("FAIL reset_pre: got pc=%0d sp=%0d exp pc=5 sp=2", bus.pc, bus.sp);
        end
        n_reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== VW'(0)) begin
            n_fail++; $display("FAIL reset_async: got %s exp all zero", fmt(obs()));
        end
        @(posedge clk); @(negedge clk);
        model_reset();
        n_reset = 1'b1;
    endtask

    task automatic test_level_wait();
        int held;
        clear_rom();
        rom[3] = mk(`WAIT, 1);
        apply_reset();
        held = 0;
        for (int i = 0; i < 8; i++) begin
            begin_cycle(i == 7, 1'b0);
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL level_wait: got %s exp %s", fmt(obs()), fmt(exp_vec));
            end
            if (bus.pc == 4'd3 && bus.issue == 1'b0) held++;
            if (i == 6) begin
                n_checks++;
                if (bus.state !== 2'd1 || bus.pc !== 4'd3) begin
                    n_fail++; $display("FAIL level_wait_held: got st=%0d pc=%0d exp st=1 pc=3", bus.state, bus.pc);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (bus.issue !== 1'b1) begin
                    n_fail++; $display("FAIL level_wait_issue: got %0d exp 1", bus.issue);
                end
            end
            end_cycle();
        end
        n_checks++;
        if (held != 4 || bus.pc !== 4'd4 || bus.state !== 2'd0) begin
            n_fail++; $display("FAIL level_wait_done: got held=%0d pc=%0d st=%0d exp 4/4/0", held, bus.pc, bus.state);
        end
    endtask

    task automatic test_edge_wait();
        bit rdy_seq [7] = '{1, 1, 1, 1, 1, 0, 1};
        int held;
        clear_rom();
        rom[2] = mk(`WAIT, 9);
        apply_reset();
        held = 0;
        for (int i = 0; i < 7; i++) begin
            begin_cycle(rdy_seq[i], 1'b0);
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL edge_wait: got %s exp %s", fmt(obs()), fmt(exp_vec));
            end
            if (bus.pc == 4'd2 && bus.issue == 1'b0) held++;
            end_cycle();
        end
        n_checks++;
        if (held != 4 || bus.pc !== 4'd3) begin
            n_fail++; $display("FAIL edge_wait_done: got held=%0d pc=%0d exp held=4 pc=3", held, bus.pc);
        end
    endtask

    task automatic test_call_ret();
        clear_rom();
        rom[2] = mk(`CALL, 9);
        rom[9] = mk(`RET, 0);
        rom[3] = mk(`CALL, 5);
        rom[5] = mk(`CALL, 6);
        rom[6] = mk(`CALL, 7);
        rom[7] = mk(`CALL, 8);
        rom[8] = mk(`CALL, 10);
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            begin_cycle(1'($urandom_range(0, 1)), (i > 9) ? 1'($urandom_range(0, 1)) : 1'b0);
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL call_ret: got %s exp %s", fmt(obs()), fmt(exp_vec));
            end
            end_cycle();
            if (i == 2) begin
                n_checks++;
                if (bus.pc !== 4'd9 || bus.sp !== 3'd1) begin
                    n_fail++; $display("FAIL call_target: got pc=%0d sp=%0d exp pc=9 sp=1", bus.pc, bus.sp);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (bus.pc !== 4'd3 || bus.sp !== 3'd0) begin
                    n_fail++; $display("FAIL ret_target: got pc=%0d sp=%0d exp pc=3 sp=0", bus.pc, bus.sp);
                end
            end
        end
        n_checks++;
        if (obs() !== {4'd8, 2'd3, 3'd4, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL overflow_frozen: got %s exp pc=8 st=3 sp=4 issue=0 err=1 to=0", fmt(obs()));
        end
        clear_rom();
        rom[0] = mk(`RET, 0);
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            begin_cycle(1'b0, 1'b0);
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL underflow: got %s exp %s", fmt(obs()), fmt(exp_vec));
            end
            end_cycle();
        end
        n_checks++;
        if (bus.state !== 2'd3 || bus.stack_err !== 1'b1 || bus.pc !== 4'd0) begin
            n_fail++; $display("FAIL underflow_fault: got st=%0d err=%0d pc=%0d exp 3/1/0", bus.state, bus.stack_err, bus.pc);
        end
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0]  = mk(`JMP, 15);
        rom[15] = mk(`CALL, 12);
        rom[12] = mk(`RET, 0);
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            begin_cycle(1'b0, 1'b0);
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL wrap: got %s exp %s", fmt(obs()), fmt(exp_vec));
            end
            end_cycle();
        end
        n_checks++;
        if (bus.pc !== 4'd0 || bus.sp !== 3'd0 || bus.stack_err !== 1'b0) begin
            n_fail++; $display("FAIL wrap_ret: got pc=%0d sp=%0d err=%0d exp 0/0/0", bus.pc, bus.sp, bus.stack_err);
        end
    endtask

    task automatic test_halt_wait();
        bit rdy_seq  [6] = '{0, 0, 0, 0, 1, 1};
        bit halt_seq [6] = '{0, 0, 1, 1, 0, 0};
        clear_rom();
        rom[0] = mk(`WAIT, 1);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            begin_cycle(rdy_seq[i], halt_seq[i]);
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL halt_wait: got %s exp %s", fmt(obs()), fmt(exp_vec));
            end
            if (i == 3 || i == 4) begin
                n_checks++;
                if (bus.state !== 2'd2 || bus.issue !== 1'b0) begin
                    n_fail++; $display("FAIL halt_state: got st=%0d issue=%0d exp st=2 issue=0", bus.state, bus.issue);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (bus.state !== 2'd0 || bus.issue !== 1'b1) begin
                    n_fail++; $display("FAIL halt_release: got st=%0d issue=%0d exp st=0 issue=1", bus.state, bus.issue);
                end
            end
            end_cycle();
        end
        n_checks++;
        if (bus.pc !== 4'd1) begin
            n_fail++; $display("FAIL halt_wait_pc: got %0d exp 1", bus.pc);
        end
    endtask

    task automatic test_timeout();
        int first_adv;
        clear_rom();
        rom[0] = mk(`WAIT, 1);
        apply_reset();
        first_adv = -1;
        for (int i = 0; i < 20; i++) begin
            begin_cycle(1'b0, 1'b0);
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++; $display("FAIL timeout: got %s exp %s", fmt(obs()), fmt(exp_vec));
            end
            end_cycle();
            if (first_adv < 0 && bus.pc != 4'd0) first_adv = i + 1;
        end
        n_checks++;
        if (first_adv != (TO_EN ? int'(WT) + 1 : -1) || bus.wait_timeout !== TO_EN) begin
            n_fail++; $display("FAIL timeout_adv: got adv=%0d to=%0d exp adv=%0d to=%0d",
                               first_adv, bus.wait_timeout, TO_EN ? int'(WT) + 1 : -1, TO_EN);
        end
    endtask

    task automatic test_random();
        int fault_cycles;
        for (int blk = 0; blk < 8; blk++) begin
            for (int a = 0; a < PS; a++)
                rom[a] = mk(3'($urandom_range(0, 7)), $urandom_range(0, 511));
            apply_reset();
            fault_cycles = 0;
            for (int i = 0; i < 200; i++) begin
                begin_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
                n_checks++;
                if (obs() !== exp_vec) begin
                    n_fail++; $display("FAIL random blk=%0d cyc=%0d: got %s exp %s", blk, i, fmt(obs()), fmt(exp_vec));
                end
                end_cycle();
                if (m_state == 3) fault_cycles++;
                if (fault_cycles > 3) begin
                    apply_reset();
                    fault_cycles = 0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_level_wait();
        test_edge_wait();
        test_call_ret();
        test_wrap();
        test_halt_wait();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
